vga_scanout_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA timing and address pair.
- Generates programmable-resolution VGA timing and the frame-buffer read address.
- Supports integer pixel replication (1x/2x/4x zoom) of an image of run-time dimensions, placed at the top-left of the screen.
- Delays sync/blank by the frame-buffer read latency so the DAC sees sync and pixel data aligned. Sits between the frame-buffer RAM and the video DAC.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing_core.sv | 85 ++++++++
 rtl/vga_scanout_gen.sv | 130 +++++++++++++
 tb/tb_vga_scanout_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared scale-mode type, default 640x480@60 timing and the zoom shift helper
// for the VGA scan-out generator.
package vga_pkg;

    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } scale_mode_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Mode 3 is not a legal zoom and falls back to 1x.
    function automatic logic [1:0] scale_shift(input logic [1:0] mode);
        logic [1:0] s;
        case (mode)
            SCALE_2X: s = 2'd1;
            SCALE_4X: s = 2'd2;
            default:  s = 2'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Horizontal/vertical raster counters, raw sync/blank decode and the delay
// line that realigns sync/blank with frame-buffer data.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int MEM_LAT  = 1,
    parameter int H_CNT_W  = 10,
    parameter int V_CNT_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [H_CNT_W-1:0] h,
    output logic [V_CNT_W-1:0] v,
    output logic               line_end,
    output logic               frame_end,
    output logic               active,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_n
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH   = 1 + MEM_LAT;
    localparam logic POL   = (SYNC_POL != 0);
    localparam logic [2:0] IDLE = {~POL, ~POL, 1'b0};

    // One spare bit so porch boundaries equal to a power of two still fit.
    logic [H_CNT_W:0] hx;
    logic [V_CNT_W:0] vx;
    logic             hs_act;
    logic             vs_act;
    logic [2:0]       raw;
    logic [2:0]       dly [DEPTH];

    assign hx = {1'b0, h};
    assign vx = {1'b0, v};

    assign line_end  = (hx == (H_CNT_W+1)'(H_TOTAL - 1));
    assign frame_end = line_end && (vx == (V_CNT_W+1)'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (line_end) begin
            h <= '0;
            v <= frame_end ? '0 : v + V_CNT_W'(1);
        end else begin
            h <= h + H_CNT_W'(1);
        end
    end

    assign hs_act = (hx >= (H_CNT_W+1)'(H_ACTIVE + H_FP)) &&
                    (hx <  (H_CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act = (vx >= (V_CNT_W+1)'(V_ACTIVE + V_FP)) &&
                    (vx <  (V_CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC));
    assign active = (hx < (H_CNT_W+1)'(H_ACTIVE)) && (vx < (V_CNT_W+1)'(V_ACTIVE));

    assign raw = {hs_act ? POL : ~POL, vs_act ? POL : ~POL, active};

    // Gated by reset so the pulse cannot appear while counters are held at 0.
    assign frame_start = ~rst && (h == '0) && (v == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) dly[i] <= IDLE;
        end else begin
            dly[0] <= raw;
            for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
        end
    end

    assign {hsync, vsync, blank_n} = dly[DEPTH-1];

endmodule

// File: rtl/vga_scanout_gen.sv
// VGA scan-out: programmable timing plus frame-buffer address generation with
// 1x/2x/4x pixel replication of a top-left image, without a multiplier.
module vga_scanout_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int DIM_W    = 8,
    parameter int ADDR_W   = 19,
    parameter int MEM_LAT  = 1
) (
    input  logic               vgaclk,
    input  logic               reset,
    input  logic [1:0]         scale_mode,
    input  logic [2*DIM_W-1:0] dimensiones,
    output logic               horizontal_sync,
    output logic               vertical_sync,
    output logic               vga_sync,
    output logic               vga_blank,
    output logic [ADDR_W-1:0]  DataAdr_out,
    output logic               enable_pixel,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_CNT_W = $clog2(H_TOTAL);
    localparam int V_CNT_W = $clog2(V_TOTAL);

    logic [H_CNT_W-1:0] h;
    logic [V_CNT_W-1:0] v;
    logic               line_end;
    logic               frame_end;
    logic               active;
    logic               at_origin;

    logic [1:0]         mode_q;
    logic [DIM_W-1:0]   width_q;
    logic [DIM_W-1:0]   height_q;
    logic [1:0]         mode_eff;
    logic [DIM_W-1:0]   width_eff;
    logic [DIM_W-1:0]   height_eff;
    logic [1:0]         shift;
    logic [1:0]         row_mask;
    logic               row_done;
    logic [DIM_W+1:0]   sw;
    logic [DIM_W+1:0]   sh;
    logic [H_CNT_W-1:0] col;
    logic [ADDR_W-1:0]  row_base;
    logic [ADDR_W-1:0]  addr_next;
    logic               visible;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL), .MEM_LAT (MEM_LAT),
        .H_CNT_W  (H_CNT_W),  .V_CNT_W (V_CNT_W)
    ) u_timing (
        .clk         (vgaclk),
        .rst         (reset),
        .h           (h),
        .v           (v),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .active      (active),
        .frame_start (frame_start),
        .hsync       (horizontal_sync),
        .vsync       (vertical_sync),
        .blank_n     (vga_blank)
    );

    assign vga_sync  = 1'b0;
    assign at_origin = (h == '0) && (v == '0);

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            mode_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else if (at_origin) begin
            mode_q   <= scale_mode;
            width_q  <= dimensiones[2*DIM_W-1:DIM_W];
            height_q <= dimensiones[DIM_W-1:0];
        end
    end

    // The origin pixel already belongs to the new frame, so it sees the
    // configuration being latched rather than the previous frame's shadow.
    assign mode_eff   = at_origin ? scale_mode : mode_q;
    assign width_eff  = at_origin ? dimensiones[2*DIM_W-1:DIM_W] : width_q;
    assign height_eff = at_origin ? dimensiones[DIM_W-1:0] : height_q;

    assign shift    = scale_shift(mode_eff);
    assign row_mask = (2'd1 << shift) - 2'd1;
    assign row_done = ((v[1:0] + 2'd1) & row_mask) == 2'd0;
    assign sw       = {2'b00, width_eff} << shift;
    assign sh       = {2'b00, height_eff} << shift;
    assign col      = h >> shift;

    // Row base steps by one image line every 2^shift raster lines.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            row_base <= '0;
        end else if (frame_end) begin
            row_base <= '0;
        end else if (line_end && row_done) begin
            row_base <= row_base + ADDR_W'(width_q);
        end
    end

    assign addr_next = row_base + ADDR_W'(col);
    assign visible   = active && (32'(h) < 32'(sw)) && (32'(v) < 32'(sh));

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            DataAdr_out  <= '0;
            enable_pixel <= 1'b0;
        end else begin
            DataAdr_out  <= visible ? addr_next : '0;
            enable_pixel <= visible;
        end
    end

endmodule

// File: tb/tb_vga_scanout_gen.sv
// Bench for vga_scanout_gen: three instances (small active-low, small
// active-high with deep RAM latency and narrow address, default 640x480).
module tb_vga_scanout_gen;

    localparam int A_HT = 56;
    localparam int A_FT = 56 * 37;
    localparam int B_FT = 32 * 25;
    localparam int C_FT = 800 * 525;

    typedef struct { int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, addr_w, lat; } tim_t;
    typedef struct { int mode, w, h; } cfg_t;
    typedef struct { int hs, vs, blank, en, fs; longint addr; } exp_t;
    typedef struct { int f, x, y, en, addr; } lit_t;
    typedef struct { int dut, sig, n, val; } slit_t;

    tim_t ta = '{40, 4, 6, 6, 30, 2, 2, 3, 0, 19, 1};
    tim_t tb = '{24, 2, 3, 3, 20, 1, 2, 2, 1, 8, 3};
    tim_t tc = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 19, 1};

    // Hand-derived pixel expectations for the scripted first frames of DUT A.
    lit_t lits [14] = '{
        '{0, 19, 0, 1, 19},  '{0, 0, 1, 1, 20},   '{0, 20, 0, 0, 0},  '{0, 0, 10, 0, 0},
        '{1, 3, 5, 1, 41},   '{1, 39, 19, 1, 199}, '{1, 40, 0, 0, 0},  '{1, 0, 20, 0, 0},
        '{2, 5, 9, 1, 185},  '{2, 0, 12, 0, 0},   '{3, 0, 1, 1, 16},  '{3, 15, 15, 1, 255},
        '{4, 39, 29, 1, 100}, '{5, 0, 0, 0, 0}
    };
    // sig: 0=horizontal_sync 1=vertical_sync 2=vga_blank 3=frame_start
    slit_t slits [20] = '{
        '{0, 0, 45, 1},   '{0, 0, 46, 0},   '{0, 0, 51, 0},   '{0, 0, 52, 1},
        '{0, 1, 1793, 1}, '{0, 1, 1794, 0}, '{0, 1, 1855, 0}, '{0, 1, 1906, 1},
        '{0, 3, 0, 1},    '{0, 3, 1, 0},    '{0, 3, 2072, 1},
        '{1, 2, 3, 0},    '{1, 2, 4, 1},    '{1, 0, 29, 0},   '{1, 0, 30, 1},
        '{2, 0, 657, 1},  '{2, 0, 658, 0},  '{2, 0, 753, 0},  '{2, 0, 754, 1},
        '{2, 0, 1458, 0}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  scale_a, scale_b;
    logic [15:0] dims_a;
    logic [11:0] dims_b;
    logic        hs_a, vs_a, sync_a, blank_a, en_a, fs_a;
    logic        hs_b, vs_b, sync_b, blank_b, en_b, fs_b;
    logic        hs_c, vs_c, sync_c, blank_c, en_c, fs_c;
    logic [18:0] addr_a, addr_c;
    logic [7:0]  addr_b;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;

    always #5 clk = ~clk;

    vga_scanout_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(0), .DIM_W(8), .ADDR_W(19), .MEM_LAT(1)
    ) dut_a (
        .vgaclk(clk), .reset(rst), .scale_mode(scale_a), .dimensiones(dims_a),
        .horizontal_sync(hs_a), .vertical_sync(vs_a), .vga_sync(sync_a), .vga_blank(blank_a),
        .DataAdr_out(addr_a), .enable_pixel(en_a), .frame_start(fs_a)
    );

    vga_scanout_gen #(
        .H_ACTIVE(24), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1), .DIM_W(6), .ADDR_W(8), .MEM_LAT(3)
    ) dut_b (
        .vgaclk(clk), .reset(rst), .scale_mode(scale_b), .dimensiones(dims_b),
        .horizontal_sync(hs_b), .vertical_sync(vs_b), .vga_sync(sync_b), .vga_blank(blank_b),
        .DataAdr_out(addr_b), .enable_pixel(en_b), .frame_start(fs_b)
    );

    vga_scanout_gen dut_c (
        .vgaclk(clk), .reset(rst), .scale_mode(scale_a), .dimensiones(dims_a),
        .horizontal_sync(hs_c), .vertical_sync(vs_c), .vga_sync(sync_c), .vga_blank(blank_c),
        .DataAdr_out(addr_c), .enable_pixel(en_c), .frame_start(fs_c)
    );

    // Reference: position of any output cycle follows from cycles since release.
    function automatic exp_t model(input tim_t t, input int n, input cfg_t c);
        exp_t e;
        int ht, ft, p, x, y, s;
        ht = t.ha + t.hfp + t.hs + t.hbp;
        ft = ht * (t.va + t.vfp + t.vs + t.vbp);
        e.fs = (n % ft == 0) ? 1 : 0;
        e.en = 0;
        e.addr = 0;
        if (n >= 1) begin
            p = (n - 1) % ft;
            x = p % ht;
            y = p / ht;
            s = (c.mode == 1) ? 1 : (c.mode == 2) ? 2 : 0;
            if (x < (c.w << s) && y < (c.h << s) && x < t.ha && y < t.va) begin
                e.en = 1;
                e.addr = longint'(((y >> s) * c.w + (x >> s)) % (1 << t.addr_w));
            end
        end
        e.hs = 1 - t.pol;
        e.vs = 1 - t.pol;
        e.blank = 0;
        if (n >= 1 + t.lat) begin
            p = (n - 1 - t.lat) % ft;
            x = p % ht;
            y = p / ht;
            if (x >= t.ha + t.hfp && x < t.ha + t.hfp + t.hs) e.hs = t.pol;
            if (y >= t.va + t.vfp && y < t.va + t.vfp + t.vs) e.vs = t.pol;
            e.blank = (x < t.ha && y < t.va) ? 1 : 0;
        end
        return e;
    endfunction

    function automatic cfg_t cfg_for(input cfg_t q[$], input int n, input int ft);
        cfg_t c;
        c = '{0, 0, 0};
        if (n >= 1 && (n - 1) / ft < q.size()) c = q[(n - 1) / ft];
        return c;
    endfunction

    task automatic chk(input string what, input int n, input logic [63:0] act, input longint exp);
        n_checks++;
        if (act !== 64'(exp)) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at n=%0d: got %0d, expected %0d", what, n, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input tim_t t, input int n, input cfg_t c,
                             input logic hs, input logic vs, input logic sync, input logic blank,
                             input logic en, input logic fs, input logic [63:0] addr);
        exp_t e;
        if (n < 0) begin
            e = '{1 - t.pol, 1 - t.pol, 0, 0, 0, 0};
        end else begin
            e = model(t, n, c);
        end
        chk({tag, " horizontal_sync"}, n, 64'(hs), e.hs);
        chk({tag, " vertical_sync"}, n, 64'(vs), e.vs);
        chk({tag, " vga_sync"}, n, 64'(sync), 0);
        chk({tag, " vga_blank"}, n, 64'(blank), e.blank);
        chk({tag, " enable_pixel"}, n, 64'(en), e.en);
        chk({tag, " frame_start"}, n, 64'(fs), e.fs);
        chk({tag, " DataAdr_out"}, n, addr, e.addr);
    endtask

    // Compare process: n is the cycle index since the last reset release.
    initial begin
        int n, releases, f, p, x, y;
        logic act;
        cfg_t q_a[$], q_b[$], q_c[$];
        n = -1;
        releases = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n = -1;
                q_a.delete();
                q_b.delete();
                q_c.delete();
            end else begin
                n = n + 1;
                if (n == 0) releases++;
                if (n % A_FT == 0) q_a.push_back('{int'(scale_a), int'(dims_a[15:8]), int'(dims_a[7:0])});
                if (n % B_FT == 0) q_b.push_back('{int'(scale_b), int'(dims_b[11:6]), int'(dims_b[5:0])});
                if (n % C_FT == 0) q_c.push_back('{int'(scale_a), int'(dims_a[15:8]), int'(dims_a[7:0])});
            end
            check_dut("a", ta, n, cfg_for(q_a, n, A_FT), hs_a, vs_a, sync_a, blank_a, en_a, fs_a, 64'(addr_a));
            check_dut("b", tb, n, cfg_for(q_b, n, B_FT), hs_b, vs_b, sync_b, blank_b, en_b, fs_b, 64'(addr_b));
            check_dut("c", tc, n, cfg_for(q_c, n, C_FT), hs_c, vs_c, sync_c, blank_c, en_c, fs_c, 64'(addr_c));
            if (n >= 0) begin
                foreach (slits[i]) begin
                    if (slits[i].n == n) begin
                        case (slits[i].dut * 4 + slits[i].sig)
                            0:  act = hs_a;
                            1:  act = vs_a;
                            3:  act = fs_a;
                            4:  act = hs_b;
                            6:  act = blank_b;
                            8:  act = hs_c;
                            default: act = fs_c;
                        endcase
                        chk($sformatf("lit sync dut%0d sig%0d", slits[i].dut, slits[i].sig), n, 64'(act), slits[i].val);
                    end
                end
            end
            if (releases == 1 && n >= 1) begin
                f = (n - 1) / A_FT;
                p = (n - 1) % A_FT;
                x = p % A_HT;
                y = p / A_HT;
                foreach (lits[i]) begin
                    if (lits[i].f == f && lits[i].x == x && lits[i].y == y) begin
                        chk($sformatf("lit a enable_pixel f%0d (%0d,%0d)", f, x, y), n, 64'(en_a), lits[i].en);
                        chk($sformatf("lit a DataAdr_out f%0d (%0d,%0d)", f, x, y), n, 64'(addr_a), lits[i].addr);
                    end
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_b();
        scale_b = 2'($urandom_range(0, 3));
        dims_b = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
    endtask

    task automatic rand_a();
        scale_a = 2'($urandom_range(0, 3));
        dims_a = {8'($urandom_range(0, 60)), 8'($urandom_range(0, 40))};
    endtask

    // Stimulus: scripted frames for A, then random reconfiguration, then a mid-line reset.
    initial begin
        rst = 1'b1;
        scale_a = 2'd0;
        dims_a = {8'd20, 8'd10};
        rand_b();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        wait_until(100);
        scale_a = 2'd1; dims_a = {8'd20, 8'd10}; rand_b();
        wait_until(A_FT + 100);
        scale_a = 2'd0; dims_a = {8'd20, 8'd10}; rand_b();
        wait_until(2 * A_FT + 15 * A_HT + 3);
        dims_a = {8'd16, 8'd16}; rand_b();
        wait_until(3 * A_FT + 100);
        scale_a = 2'd2; dims_a = {8'd13, 8'd9}; rand_b();
        wait_until(4 * A_FT + 100);
        scale_a = 2'd3; dims_a = {8'd0, 8'd10}; rand_b();
        wait_until(5 * A_FT + 100);

        for (int i = 0; i < 60; i++) begin
            wait_until(cyc + $urandom_range(50, 400));
            rand_a();
            rand_b();
        end

        wait_until(cyc + 123);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2500) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
